usb_tx_frame_writer: RTL and testbench

Downstream stage of the USB control-register reader. Grants the reader's two transmit requests (general and system-time), captures the framed byte stream it emits (0x4D marker, address, length, payload) into an internal FIFO, and drains that FIFO to the FT245-style synchronous USB FIFO chip through the TXE#/WR# handshake. It also guards against buffer overflow and stalled frames.

---
 rtl/usb_tx_frame_writer.sv | 194 +++++++++++++++++++
 tb/tb_usb_tx_frame_writer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_frame_writer.sv
// Grants reader transmit requests, buffers framed bytes in a FIFO and drains them to an FT245-style USB FIFO.
// Optional frame counter output enabled by defining USB_TX_FRAME_COUNT_EN.
module usb_tx_frame_writer #(
   parameter int DEPTH     = 64,
   parameter int AW        = 6,
   parameter int MAX_FRAME = 36,
   parameter int TIMEOUT   = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rdy_in,
   input  logic          st_rdy_in,
   output logic          ack_out,
   output logic          st_ack_out,
   input  logic [7:0]    din,
   input  logic          din_valid,
   input  logic          din_last,
   input  logic          txe_n,
   output logic          wr_n,
   output logic [7:0]    usb_d,
   output logic [AW:0]   level,
   output logic          busy,
   output logic          overflow,
   output logic          frame_err
`ifdef USB_TX_FRAME_COUNT_EN
   ,
   output logic [15:0]   frame_cnt
`endif
);

   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic {G_IDLE, G_RECV} g_state_t;
   typedef enum logic [1:0] {D_IDLE, D_SETUP, D_STROBE} d_state_t;

   g_state_t        g_q, g_d;
   d_state_t        dr_q, dr_d;
   logic            ack_q, ack_d, st_ack_q, st_ack_d;
   logic [WW-1:0]   wd_q, wd_d;
   logic            wr_n_q, wr_n_d;
   logic [7:0]      usb_d_q, usb_d_d;
   logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]     level_q, level_d, free_s;
   logic            busy_q, busy_d, ovf_q, ovf_d, ferr_q, ferr_d;
   logic            push_s, pop_s, full_s, wr_en_s;
   logic [7:0]      mem [DEPTH];

   assign free_s  = (AW+1)'(DEPTH) - level_q;
   assign full_s  = (level_q == (AW+1)'(DEPTH));
   assign wr_en_s = push_s && (!full_s || pop_s);

   // Grant FSM: one outstanding grant, system-time request wins ties, watchdog bounds RECV.
   always_comb begin
      g_d      = g_q;
      ack_d    = 1'b0;
      st_ack_d = 1'b0;
      wd_d     = wd_q;
      ferr_d   = ferr_q;
      push_s   = 1'b0;
      case (g_q)
         G_IDLE: begin
            if ((rdy_in || st_rdy_in) && (free_s >= (AW+1)'(MAX_FRAME))) begin
               st_ack_d = st_rdy_in;
               ack_d    = ~st_rdy_in;
               wd_d     = {WW{1'b0}};
               g_d      = G_RECV;
            end else begin
               g_d = G_IDLE;
            end
         end
         G_RECV: begin
            push_s = din_valid;
            wd_d   = wd_q + WW'(1);
            if (din_valid && din_last) begin
               g_d = G_IDLE;
            end else if (wd_q == WW'(TIMEOUT - 1)) begin
               g_d    = G_IDLE;
               ferr_d = 1'b1;
            end else begin
               g_d = G_RECV;
            end
         end
         default: g_d = G_IDLE;
      endcase
   end

   // Drain FSM: setup cycle presents the head byte before the one-cycle WR# strobe.
   always_comb begin
      dr_d    = dr_q;
      wr_n_d  = 1'b1;
      usb_d_d = usb_d_q;
      pop_s   = 1'b0;
      case (dr_q)
         D_IDLE: begin
            if ((level_q != {(AW+1){1'b0}}) && !txe_n) begin
               dr_d    = D_SETUP;
               usb_d_d = mem[rptr_q];
            end else begin
               dr_d = D_IDLE;
            end
         end
         D_SETUP: begin
            if (txe_n) begin
               dr_d = D_IDLE;
            end else begin
               dr_d   = D_STROBE;
               wr_n_d = 1'b0;
            end
         end
         D_STROBE: begin
            pop_s = 1'b1;
            dr_d  = D_IDLE;
         end
         default: dr_d = D_IDLE;
      endcase
   end

   // FIFO bookkeeping: a full FIFO still accepts a write when a pop frees a slot the same cycle.
   always_comb begin
      wptr_d = wr_en_s ? (wptr_q + AW'(1)) : wptr_q;
      rptr_d = pop_s   ? (rptr_q + AW'(1)) : rptr_q;
      ovf_d  = ovf_q | (push_s && full_s && !pop_s);
      case ({wr_en_s, pop_s})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
      busy_d = (g_d == G_RECV) || (level_d != {(AW+1){1'b0}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         g_q      <= G_IDLE;
         dr_q     <= D_IDLE;
         ack_q    <= 1'b0;
         st_ack_q <= 1'b0;
         wd_q     <= {WW{1'b0}};
         wr_n_q   <= 1'b1;
         usb_d_q  <= 8'h00;
         wptr_q   <= {AW{1'b0}};
         rptr_q   <= {AW{1'b0}};
         level_q  <= {(AW+1){1'b0}};
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         g_q      <= g_d;
         dr_q     <= dr_d;
         ack_q    <= ack_d;
         st_ack_q <= st_ack_d;
         wd_q     <= wd_d;
         wr_n_q   <= wr_n_d;
         usb_d_q  <= usb_d_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         level_q  <= level_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
         ferr_q   <= ferr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem[wptr_q] <= din;
      end
   end

`ifdef USB_TX_FRAME_COUNT_EN
   logic        frame_done_s;
   logic [15:0] fcnt_q;
   assign frame_done_s = (g_q == G_RECV) && din_valid && din_last;

   // Only frames closed by din_last are counted; timed-out frames are not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fcnt_q <= 16'h0000;
      end else if (frame_done_s) begin
         fcnt_q <= fcnt_q + 16'h0001;
      end
   end
   assign frame_cnt = fcnt_q;
`endif

   assign ack_out    = ack_q;
   assign st_ack_out = st_ack_q;
   assign wr_n       = wr_n_q;
   assign usb_d      = usb_d_q;
   assign level      = level_q;
   assign busy       = busy_q;
   assign overflow   = ovf_q;
   assign frame_err  = ferr_q;

endmodule

// File: tb/tb_usb_tx_frame_writer.sv
// Table-driven and directed-sequence bench for usb_tx_frame_writer (default parameters).
module tb_usb_tx_frame_writer;

   logic       clk = 1'b0, rst = 1'b1;
   logic       rdy_in = 1'b0, st_rdy_in = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0, din_last = 1'b0, txe_n = 1'b1;
   logic       ack_out, st_ack_out, wr_n, busy, overflow, frame_err;
   logic [7:0] usb_d;
   logic [6:0] level;
`ifdef USB_TX_FRAME_COUNT_EN
   logic [15:0] frame_cnt;
`endif

   int nchk = 0, nerr = 0;
   logic [7:0] got[$];
   logic [7:0] fb[12] = '{8'h4D, 8'h01, 8'h00, 8'h08, 8'h11, 8'h12, 8'h13, 8'h14,
                          8'h15, 8'h16, 8'h17, 8'h18};

   typedef struct {
      logic       rdy; logic st; logic dv; logic dl; logic [7:0] d; logic txe_n;
      logic       e_ack; logic e_st; logic [6:0] e_lvl; logic e_busy; logic e_wr_n;
   } vec_t;
   vec_t tbl[15];

   usb_tx_frame_writer dut (
      .clk(clk), .rst(rst), .rdy_in(rdy_in), .st_rdy_in(st_rdy_in),
      .ack_out(ack_out), .st_ack_out(st_ack_out), .din(din), .din_valid(din_valid),
      .din_last(din_last), .txe_n(txe_n), .wr_n(wr_n), .usb_d(usb_d), .level(level),
      .busy(busy), .overflow(overflow), .frame_err(frame_err)
`ifdef USB_TX_FRAME_COUNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drains the FIFO, collecting every byte seen while wr_n is low.
   task automatic drain_all(input int budget, input string nm);
      logic       prev_low;
      logic [7:0] prev_d;
      prev_low = 1'b0;
      prev_d   = usb_d;
      got.delete();
      din_valid = 1'b0;
      txe_n     = 1'b0;
      for (int n = 0; n < budget; n++) begin
         step();
         if (!wr_n) begin
            got.push_back(usb_d);
            chk({nm, "_single_low"}, {31'd0, prev_low}, 32'd0);
            chk({nm, "_setup_stable"}, {24'd0, usb_d}, {24'd0, prev_d});
         end
         prev_low = !wr_n;
         prev_d   = usb_d;
         if (level == 7'd0 && wr_n) break;
      end
      chk({nm, "_empty"}, {25'd0, level}, 32'd0);
      txe_n = 1'b1;
   endtask

   initial begin
      logic       flag;
      logic [6:0] lvl_prev;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'd0, 1'b1, 1'b1};
      for (int i = 0; i < 12; i++)
         tbl[i+1] = '{1'b0, 1'b0, 1'b1, (i == 11), fb[i], 1'b1, 1'b0, 1'b0, 7'(i+1), 1'b1, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, 7'd12, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 7'd12, 1'b1, 1'b1};

      step(); step();
      chk("rst_ack", {31'd0, ack_out}, 32'd0);
      chk("rst_st_ack", {31'd0, st_ack_out}, 32'd0);
      chk("rst_usb_d", {24'd0, usb_d}, 32'd0);
      chk("rst_level", {25'd0, level}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_wr_n", {31'd0, wr_n}, 32'd1);
      rst = 1'b0;
      step();

      // Single frame, receive phase with txe_n held high
      for (int i = 0; i < 15; i++) begin
         rdy_in = tbl[i].rdy; st_rdy_in = tbl[i].st; din_valid = tbl[i].dv;
         din_last = tbl[i].dl; din = tbl[i].d; txe_n = tbl[i].txe_n;
         step();
         chk($sformatf("vec%0d_ack", i), {31'd0, ack_out}, {31'd0, tbl[i].e_ack});
         chk($sformatf("vec%0d_st_ack", i), {31'd0, st_ack_out}, {31'd0, tbl[i].e_st});
         chk($sformatf("vec%0d_level", i), {25'd0, level}, {25'd0, tbl[i].e_lvl});
         chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
         chk($sformatf("vec%0d_wr_n", i), {31'd0, wr_n}, {31'd0, tbl[i].e_wr_n});
      end
      din_valid = 1'b0; din_last = 1'b0;
      drain_all(100, "sf");
      chk("sf_count", got.size(), 32'd12);
      for (int i = 0; i < 12 && i < got.size(); i++)
         chk($sformatf("sf_byte%0d", i), {24'd0, got[i]}, {24'd0, fb[i]});
      chk("sf_busy_end", {31'd0, busy}, 32'd0);

      // Priority: both requests together, general request held through the frame
      rdy_in = 1'b1; st_rdy_in = 1'b1;
      step();
      chk("prio_st_ack", {31'd0, st_ack_out}, 32'd1);
      chk("prio_ack_first", {31'd0, ack_out}, 32'd0);
      st_rdy_in = 1'b0; din = 8'hA1; din_valid = 1'b1;
      step();
      chk("prio_st_ack_once", {31'd0, st_ack_out}, 32'd0);
      din = 8'hA2; din_last = 1'b1;
      step();
      chk("prio_ack_at_last", {31'd0, ack_out}, 32'd0);
      din_valid = 1'b0; din_last = 1'b0;
      step();
      chk("prio_ack_2cyc", {31'd0, ack_out}, 32'd1);
      rdy_in = 1'b0; din = 8'hA3; din_valid = 1'b1; din_last = 1'b1;
      step();
      chk("prio_ack_once", {31'd0, ack_out}, 32'd0);
      chk("prio_level", {25'd0, level}, 32'd3);
      din_valid = 1'b0; din_last = 1'b0;
      drain_all(60, "prio");
      chk("prio_count", got.size(), 32'd3);
      if (got.size() == 3) begin
         chk("prio_b0", {24'd0, got[0]}, 32'hA1);
         chk("prio_b2", {24'd0, got[2]}, 32'hA3);
      end

      // Backpressure: 36-byte frame with txe_n high, then a held request
      rdy_in = 1'b1;
      step();
      chk("bp_ack", {31'd0, ack_out}, 32'd1);
      rdy_in = 1'b0; flag = 1'b1;
      for (int i = 0; i < 36; i++) begin
         din = 8'(8'h40 + i); din_valid = 1'b1; din_last = (i == 35);
         step();
         if (!wr_n) flag = 1'b0;
      end
      din_valid = 1'b0; din_last = 1'b0;
      chk("bp_level", {25'd0, level}, 32'd36);
      chk("bp_wr_n_high", {31'd0, flag}, 32'd1);
      rdy_in = 1'b1; flag = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (ack_out) flag = 1'b1;
      end
      chk("bp_no_ack_full", {31'd0, flag}, 32'd0);
      txe_n = 1'b0; lvl_prev = level;
      for (int i = 0; i < 100; i++) begin
         lvl_prev = level;
         step();
         if (ack_out) break;
      end
      chk("bp_ack_after_drain", {31'd0, ack_out}, 32'd1);
      chk("bp_grant_level", {25'd0, lvl_prev}, 32'd28);
      rdy_in = 1'b0; din = 8'hEE; din_valid = 1'b1; din_last = 1'b1;
      step();
      din_valid = 1'b0; din_last = 1'b0;
      drain_all(300, "bp");
      if (got.size() > 0) chk("bp_last_byte", {24'd0, got[got.size()-1]}, 32'hEE);
      else chk("bp_got_any", got.size(), 32'd1);

      // Overflow: 70 writes into a 64-byte FIFO, txe_n high
      rdy_in = 1'b1;
      step();
      chk("ovf_ack", {31'd0, ack_out}, 32'd1);
      rdy_in = 1'b0;
      for (int i = 0; i < 70; i++) begin
         din = 8'(i); din_valid = 1'b1; din_last = (i == 69);
         step();
         if (i == 63) begin
            chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
            chk("ovf_level64", {25'd0, level}, 32'd64);
         end
      end
      din_valid = 1'b0; din_last = 1'b0;
      chk("ovf_level_sat", {25'd0, level}, 32'd64);
      chk("ovf_flag", {31'd0, overflow}, 32'd1);
      drain_all(300, "ovf");
      chk("ovf_count", got.size(), 32'd64);
      for (int i = 0; i < 64 && i < got.size(); i++)
         chk($sformatf("ovf_byte%0d", i), {24'd0, got[i]}, i);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);

      // Timeout: grant, then silence
      rdy_in = 1'b1;
      step();
      chk("to_ack", {31'd0, ack_out}, 32'd1);
      rdy_in = 1'b0;
`ifdef USB_TX_FRAME_COUNT_EN
      chk("cnt_before_to", {16'd0, frame_cnt}, 32'd6);
`endif
      repeat (200) step();
      chk("to_ferr_early", {31'd0, frame_err}, 32'd0);
      chk("to_busy_recv", {31'd0, busy}, 32'd1);
      repeat (60) step();
      chk("to_ferr", {31'd0, frame_err}, 32'd1);
      chk("to_busy_idle", {31'd0, busy}, 32'd0);
      rdy_in = 1'b1;
      step();
      chk("to_regrant", {31'd0, ack_out}, 32'd1);
`ifdef USB_TX_FRAME_COUNT_EN
      chk("cnt_after_to", {16'd0, frame_cnt}, 32'd6);
`endif
      rdy_in = 1'b0; din = 8'h55; din_valid = 1'b1; din_last = 1'b1;
      step();
      din_valid = 1'b0; din_last = 1'b0;
`ifdef USB_TX_FRAME_COUNT_EN
      chk("cnt_after_frame", {16'd0, frame_cnt}, 32'd7);
`endif

      // Reset in the middle of a strobe
      txe_n = 1'b0; flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!wr_n) begin
            flag = 1'b1;
            break;
         end
      end
      chk("rd_saw_strobe", {31'd0, flag}, 32'd1);
      chk("rd_ferr_sticky", {31'd0, frame_err}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rd_wr_n_async", {31'd0, wr_n}, 32'd1);
      chk("rd_level_async", {25'd0, level}, 32'd0);
      chk("rd_ferr_clr", {31'd0, frame_err}, 32'd0);
      chk("rd_ovf_clr", {31'd0, overflow}, 32'd0);
      step();
      rst = 1'b0; flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!wr_n) flag = 1'b1;
      end
      chk("rd_no_strobe", {31'd0, flag}, 32'd0);
      chk("rd_busy", {31'd0, busy}, 32'd0);
      txe_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
